// File: rtl/present_keysched.sv
// present_keysched
//   PRESENT block-cipher key schedule. A user key is loaded into the key
//   register and NUM_RK round keys are handed out one at a time over a
//   valid/ready handshake. The round key is always the top 64 bits of the
//   key register; the register is advanced by the PRESENT update only when
//   a round key is consumed and another one is still to come.
//
// Parameters
//   KEY_WIDTH  key length, 80 or 128
//   NUM_RK     round keys produced per loaded key, 2..32
//
// Ports
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   key_in    user key, captured when key_load is high
//   key_load  start request, accepted in any state, wins over a transfer
//   rk_ready  consumer ready for the current round key
//   rk_valid  rk_out / rk_index valid (state RUN)
//   rk_out    current round key (top 64 bits of the key register)
//   rk_index  round-key number minus one (0 = K1)
//   busy      high while round keys are being produced
//   done      high in the cycle the last round key is transferred
module present_keysched #(
  parameter int KEY_WIDTH = 80,
  parameter int NUM_RK    = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [KEY_WIDTH-1:0] key_in,
  input  logic                 key_load,
  input  logic                 rk_ready,
  output logic                 rk_valid,
  output logic [63:0]          rk_out,
  output logic [4:0]           rk_index,
  output logic                 busy,
  output logic                 done
);

  generate
    if (!(KEY_WIDTH == 80 || KEY_WIDTH == 128)) begin : g_bad_key_width
      $error("present_keysched: KEY_WIDTH must be 80 or 128");
    end
    if (NUM_RK < 2 || NUM_RK > 32) begin : g_bad_num_rk
      $error("present_keysched: NUM_RK must be in 2..32");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(NUM_RK - 1);
  // Position of the 5-bit round counter inside the key register.
  localparam int CNT_LSB = (KEY_WIDTH == 80) ? 15 : 62;

  state_t               state;
  logic [KEY_WIDTH-1:0] key_reg;
  logic                 xfer;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Rotate left by 61, substitute the top nibble(s), mix in the counter.
  function automatic logic [KEY_WIDTH-1:0] next_key(input logic [KEY_WIDTH-1:0] k,
                                                    input logic [4:0]           cnt);
    logic [KEY_WIDTH-1:0] r;
    r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
    r[KEY_WIDTH-1 -: 4] = sbox(r[KEY_WIDTH-1 -: 4]);
    if (KEY_WIDTH == 128) begin
      r[KEY_WIDTH-5 -: 4] = sbox(r[KEY_WIDTH-5 -: 4]);
    end
    r[CNT_LSB +: 5] = r[CNT_LSB +: 5] ^ cnt;
    return r;
  endfunction

  // rk_valid follows the state directly so K1 is offered the cycle after load.
  assign rk_valid = (state == RUN);
  assign busy     = rk_valid;
  assign xfer     = rk_valid & rk_ready & ~key_load;
  assign done     = xfer & (rk_index == LAST_IDX);
  assign rk_out   = key_reg[KEY_WIDTH-1 -: 64];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      key_reg  <= '0;
      rk_index <= '0;
    end else if (key_load) begin
      // A new load abandons whatever sequence was running.
      state    <= RUN;
      key_reg  <= key_in;
      rk_index <= '0;
    end else if (xfer) begin
      if (rk_index == LAST_IDX) begin
        // Last key consumed: register and index keep showing it in IDLE.
        state <= IDLE;
      end else begin
        key_reg  <= next_key(key_reg, rk_index + 5'd1);
        rk_index <= rk_index + 5'd1;
      end
    end
  end

endmodule
